// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines and a single outstanding fill.
// Hits return in 1 cycle; misses wait as long as needed for mc_done_i, and a flush drops the pending delivery.
module icache #(
  parameter int INDEX_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        if_req_i,
  input  logic [31:0] if_pc_i,
  input  logic        clr_i,
  output logic        if_ok_o,
  output logic [31:0] if_inst_o,
  output logic        mc_req_o,
  output logic [31:0] mc_addr_o,
  input  logic        mc_done_i,
  input  logic [31:0] mc_val_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic                drop_q, drop_d;
  logic                if_ok_q, if_ok_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic [31:0]         mc_addr_q, mc_addr_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic                hit, fill_we;
  logic                unused_pc_lsb;

  assign req_idx       = if_pc_i[INDEX_W+1:2];
  assign req_tag       = if_pc_i[31:INDEX_W+2];
  assign fill_idx      = mc_addr_q[INDEX_W+1:2];
  assign fill_tag      = mc_addr_q[31:INDEX_W+2];
  assign hit           = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_pc_lsb = ^if_pc_i[1:0];

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    if_ok_d   = 1'b0;
    if_inst_d = if_inst_q;
    mc_addr_d = mc_addr_q;
    fill_we   = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush in the request cycle suppresses both the hit delivery and the fill.
        if (if_req_i && !clr_i) begin
          if (hit) begin
            if_ok_d   = 1'b1;
            if_inst_d = data_mem[req_idx];
          end else begin
            mc_addr_d = {if_pc_i[31:2], 2'b00};
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        if (mc_done_i) begin
          fill_we = 1'b1;
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!(drop_q || clr_i)) begin
            if_ok_d   = 1'b1;
            if_inst_d = mc_val_i;
          end
        end else if (clr_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      if_ok_q   <= 1'b0;
      if_inst_q <= '0;
      mc_addr_q <= '0;
      valid_q   <= '0;
    end else if (rdy_i) begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      if_ok_q   <= if_ok_d;
      if_inst_q <= if_inst_d;
      mc_addr_q <= mc_addr_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (!rst && rdy_i && fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mc_val_i;
    end
  end

  assign mc_req_o  = (state_q == FILL) && !mc_done_i;
  assign mc_addr_o = mc_addr_q;
  assign if_ok_o   = if_ok_q;
  assign if_inst_o = if_inst_q;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_W, default 5, index bits; the cache holds 2^INDEX_W one-word lines.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; low freezes all registers.
REQ-005 if_req  input  1  fetch request from fetch stage.
REQ-006 if_pc  input  32  fetch address; bits [1:0] ignored.
REQ-007 clr  input  1  pipeline flush; cancels the pending delivery to fetch.
REQ-008 if_ok  output  1  one-cycle pulse: if_inst is valid.
REQ-009 if_inst  output  32  fetched instruction word.
REQ-010 mc_req  output  1  instruction request to the memory controller.
REQ-011 mc_addr  output  32  word-aligned fill address.
REQ-012 mc_done  input  1  one-cycle controller completion pulse.
REQ-013 mc_val  input  32  fill word; valid only while mc_done=1.

Function
REQ-014 Storage: per line a valid bit, tag = pc[31:INDEX_W+2], data word; index = pc[INDEX_W+1:2].
REQ-015 FSM states: IDLE, FILL.
REQ-016 IDLE, if_req=1, hit: next cycle if_ok=1 and if_inst=stored word (1-cycle latency); back-to-back hits give if_ok every cycle.
REQ-017 IDLE, if_req=1, miss: latch {if_pc[31:2],2'b00} into mc_addr, enter FILL, if_ok=0 next cycle.
REQ-018 mc_req = (state==FILL) & !mc_done, combinational; it drops in the cycle mc_done is seen, so the controller never starts a second fetch.
REQ-019 mc_addr is constant for the whole of FILL; mc_req never deasserts in FILL before mc_done.
REQ-020 FILL, mc_done=1: write valid=1, tag and mc_val into the indexed line; next cycle if_ok=1 and if_inst=mc_val unless drop is set; state becomes IDLE.
REQ-021 Fill latency is unbounded, because the controller serves data traffic first; the cache waits indefinitely.
REQ-022 if_req is ignored in FILL; a new request is accepted the cycle after return to IDLE.
REQ-023 clr in IDLE: if_ok=0 next cycle even if the same cycle hits or misses; a miss in that cycle does not start a fill.
REQ-024 clr in FILL: set drop flag; the fill still completes and is written into the array, but no if_ok is produced; drop clears on return to IDLE.
REQ-025 clr and mc_done in the same cycle: the line is written and if_ok=0.
REQ-026 clr never invalidates array contents.
REQ-027 if_ok is 0 in every cycle not named in REQ-016/020.
REQ-028 if_inst holds its last value when if_ok=0.
REQ-029 rdy=0: no register, array or FSM update; mc_req keeps its combinational value from the frozen state.

Reset
REQ-030 rst=1: state IDLE, all valid bits 0, drop 0, if_ok 0, if_inst 0, mc_addr 0; mc_req 0 in the same cycle via the state.
REQ-031 Reset during FILL aborts the fill with no array write; the controller is reset by the same rst.
REQ-032 rst has priority over rdy and every other input.

Verification
REQ-033 Cold miss: reset; if_req=1 with if_pc=0x1004; mc_done after 5 cycles with mc_val=0x00A00093 -> mc_req=1 with mc_addr=0x1004 throughout, mc_req low in the mc_done cycle, if_ok=1 with if_inst=0x00A00093 the next cycle.
REQ-034 Hit after fill: repeat if_pc=0x1004 -> if_ok=1 one cycle later, inst 0x00A00093, mc_req stays 0.
REQ-035 Conflict: with INDEX_W=5, fill 0x1004, then request 0x1084 (same index, different tag) -> miss and fill; then 0x1004 misses again.
REQ-036 Flush during fill: miss on 0x2000, clr pulse 2 cycles later, mc_done with 0x12345678 -> no if_ok; a later request for 0x2000 hits with 0x12345678.
REQ-037 rdy stall: rdy=0 for 3 cycles during FILL with mc_done=0 -> state, mc_addr and mc_req unchanged; fill completes normally after rdy=1.
REQ-038 Reset mid-fill: rst during FILL -> mc_req=0 and if_ok=0; a request for the same address misses again.
